pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline.
- Drives the `stall`/`refresh` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers.
- Sequences the multi-cycle mult/div unit with a cycle counter.
- Resolves load-use hazards, waits on the instruction and data buses, and flushes on exception/eret, including discarding an in-flight fetch.

---
 rtl/pipe_hazard_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Resolves, in strict priority order, exception/eret flushes, data-bus
// waits, multi-cycle mult/div occupancy, load-use hazards and instruction
// fetch waits. Each hazard produces a stall on the segments upstream of the
// blocked stage and a bubble (refresh) into the segment directly after it.
// The mult/div unit is sequenced by a down-counter, and a small flush FSM
// remembers to drop the data of a fetch that was in flight at flush time.
//
// Start/done protocol with the mult/div unit: md_start is a single-cycle
// pulse issued in the cycle the operation is accepted (the unit captures
// operands at that edge). md_done is high for every cycle in which the
// result is valid and stays high while data_busy holds the pipeline.
// md_cancel aborts an accepted operation. There is no back-pressure from
// the unit; its latency is fixed by MUL_CYCLES/DIV_CYCLES.
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             resetn,
  // ID-stage source operands
  input  logic             id_rs_ren,
  input  logic             id_rt_ren,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  // EX-stage instruction attributes
  input  logic             ex_load,
  input  logic             ex_regwen,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_mult,
  input  logic             ex_div,
  // bus and commit status
  input  logic             inst_busy,
  input  logic             data_busy,
  input  logic             exc_valid,
  input  logic             eret_valid,
  // segment register controls
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             mem_wb_stall,
  output logic             if_id_refresh,
  output logic             id_ex_refresh,
  output logic             ex_mem_refresh,
  output logic             mem_wb_refresh,
  // mult/div unit sequencing
  output logic             md_start,
  output logic             md_done,
  output logic             md_cancel,
  // fetch control
  output logic             fetch_discard,
  // debug visibility of internal state
  output logic [1:0]       dbg_md_state_o,
  output logic             dbg_fl_state_o,
  output logic [CNT_W-1:0] dbg_cnt_o
);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef enum logic {
    FL_IDLE = 1'b0,
    FL_WAIT = 1'b1
  } fl_state_e;

  // Counter reload values: the counter holds the remaining BUSY cycles.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  md_state_e        md_state_q, md_state_d;
  fl_state_e        fl_state_q, fl_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             flush;
  logic             load_use;
  logic             md_req;
  logic             md_hold;
  logic             md_accept;
  logic [CNT_W-1:0] md_load;

  assign dbg_md_state_o = md_state_q;
  assign dbg_fl_state_o = fl_state_q;
  assign dbg_cnt_o      = cnt_q;

  // Hazard terms derived from the current instruction mix and md state.
  always_comb begin
    flush     = exc_valid | eret_valid;
    load_use  = ex_load & ex_regwen & (ex_wreg != 5'd0) &
                ((id_rs_ren & (id_rs == ex_wreg)) |
                 (id_rt_ren & (id_rt == ex_wreg)));
    md_req    = ex_mult | ex_div;
    md_hold   = (md_state_q == MD_BUSY) | ((md_state_q == MD_IDLE) & md_req);
    // An op is only accepted when the pipeline is otherwise free to move.
    md_accept = (md_state_q == MD_IDLE) & md_req & ~flush & ~data_busy;
    // div wins when both flags are set.
    md_load   = ex_div ? DIV_LOAD : MUL_LOAD;
  end

  // State registers for both FSMs and the mult/div cycle counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      md_state_q <= MD_IDLE;
      fl_state_q <= FL_IDLE;
      cnt_q      <= CNT_ZERO;
    end else begin
      md_state_q <= md_state_d;
      fl_state_q <= fl_state_d;
      cnt_q      <= cnt_d;
    end
  end

  // Mult/div sequencing: load on accept, count down while the pipeline
  // is not frozen by the data bus, then present the result for one cycle.
  always_comb begin
    md_state_d = md_state_q;
    cnt_d      = cnt_q;
    if (flush) begin
      md_state_d = MD_IDLE;
      cnt_d      = CNT_ZERO;
    end else begin
      unique case (md_state_q)
        MD_IDLE: begin
          if (md_accept) begin
            cnt_d      = md_load;
            md_state_d = (md_load == CNT_ZERO) ? MD_DONE : MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (!data_busy) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              md_state_d = MD_DONE;
            end
          end
        end
        MD_DONE: begin
          // The instruction leaves EX at the edge where data_busy is low.
          if (!data_busy) begin
            md_state_d = MD_IDLE;
          end
        end
        default: begin
          md_state_d = MD_IDLE;
          cnt_d      = CNT_ZERO;
        end
      endcase
    end
  end

  // Flush FSM: remember an in-flight fetch at flush time until it retires.
  always_comb begin
    fl_state_d = fl_state_q;
    unique case (fl_state_q)
      FL_IDLE: fl_state_d = (flush & inst_busy) ? FL_WAIT : FL_IDLE;
      FL_WAIT: fl_state_d = inst_busy ? FL_WAIT : FL_IDLE;
      default: fl_state_d = FL_IDLE;
    endcase
  end

  // Prioritised stall/refresh generation. Each level stalls every segment
  // up to the blocked stage and bubbles the segment directly after it.
  always_comb begin
    if_id_stall    = 1'b0;
    id_ex_stall    = 1'b0;
    ex_mem_stall   = 1'b0;
    mem_wb_stall   = 1'b0;
    if_id_refresh  = 1'b0;
    id_ex_refresh  = 1'b0;
    ex_mem_refresh = 1'b0;
    mem_wb_refresh = 1'b0;
    md_start       = 1'b0;
    md_done        = 1'b0;
    md_cancel      = 1'b0;
    fetch_discard  = 1'b0;
    if (resetn) begin
      if (flush) begin
        if_id_refresh  = 1'b1;
        id_ex_refresh  = 1'b1;
        ex_mem_refresh = 1'b1;
        mem_wb_refresh = 1'b1;
      end else if (data_busy) begin
        if_id_stall    = 1'b1;
        id_ex_stall    = 1'b1;
        ex_mem_stall   = 1'b1;
        mem_wb_refresh = 1'b1;
      end else if (md_hold) begin
        if_id_stall    = 1'b1;
        id_ex_stall    = 1'b1;
        ex_mem_refresh = 1'b1;
      end else if (load_use) begin
        if_id_stall    = 1'b1;
        id_ex_refresh  = 1'b1;
      end else if (inst_busy) begin
        // Covers the post-flush wait too: no valid fetch reaches ID.
        if_id_refresh  = 1'b1;
      end
      md_start      = md_accept;
      // A result being discarded by a flush is not reported as done.
      md_done       = (md_state_q == MD_DONE) & ~flush;
      md_cancel     = flush & (md_state_q != MD_IDLE);
      fetch_discard = (fl_state_q == FL_WAIT) & inst_busy;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the controller.
module tb_pipe_hazard_ctrl;

  localparam int MUL_CYCLES = 2;
  localparam int DIV_CYCLES = 33;
  localparam int CNT_W      = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       id_rs_ren, id_rt_ren;
  logic [4:0] id_rs, id_rt;
  logic       ex_load, ex_regwen;
  logic [4:0] ex_wreg;
  logic       ex_mult, ex_div;
  logic       inst_busy, data_busy, exc_valid, eret_valid;

  logic if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh;
  logic md_start, md_done, md_cancel, fetch_discard;
  logic [1:0]       dbg_md_state;
  logic             dbg_fl_state;
  logic [CNT_W-1:0] dbg_cnt;

  pipe_hazard_ctrl #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_load(ex_load), .ex_regwen(ex_regwen), .ex_wreg(ex_wreg),
    .ex_mult(ex_mult), .ex_div(ex_div),
    .inst_busy(inst_busy), .data_busy(data_busy),
    .exc_valid(exc_valid), .eret_valid(eret_valid),
    .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .if_id_refresh(if_id_refresh), .id_ex_refresh(id_ex_refresh),
    .ex_mem_refresh(ex_mem_refresh), .mem_wb_refresh(mem_wb_refresh),
    .md_start(md_start), .md_done(md_done), .md_cancel(md_cancel),
    .fetch_discard(fetch_discard),
    .dbg_md_state_o(dbg_md_state), .dbg_fl_state_o(dbg_fl_state),
    .dbg_cnt_o(dbg_cnt)
  );

  // Output vector bit map:
  // 11 if_id_stall 10 id_ex_stall 9 ex_mem_stall 8 mem_wb_stall
  // 7 if_id_refresh 6 id_ex_refresh 5 ex_mem_refresh 4 mem_wb_refresh
  // 3 md_start 2 md_done 1 md_cancel 0 fetch_discard
  logic [11:0] dut_vec;
  assign dut_vec = {if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                    if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh,
                    md_start, md_done, md_cancel, fetch_discard};

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_md: 0 = no op, 1 = op counting, 2 = result available
  // m_left: counting cycles still to elapse before the result is available
  // m_disc: a fetch that was in flight at flush time has not retired yet
  int m_md   = 0;
  int m_left = 0;
  bit m_disc = 1'b0;

  function automatic logic [11:0] model_expect();
    logic       flush, lu, hold, start, done, cancel, disc;
    logic [3:0] st, rf;
    int         k;
    if (!resetn) return 12'd0;
    flush = exc_valid | eret_valid;
    lu    = ex_load && ex_regwen && (ex_wreg != 0) &&
            ((id_rs_ren && id_rs == ex_wreg) || (id_rt_ren && id_rt == ex_wreg));
    hold  = (m_md == 1) || (m_md == 0 && (ex_mult || ex_div));
    st = 4'd0;
    rf = 4'd0;
    if (flush) begin
      rf = 4'hF;
    end else begin
      // k = number of segments (from IF/ID onwards) that must hold
      k = data_busy ? 3 : hold ? 2 : lu ? 1 : 0;
      for (int s = 0; s < k; s++) st[s] = 1'b1;
      if (k > 0) rf[k] = 1'b1;
      else if (inst_busy) rf[0] = 1'b1;
    end
    start  = (m_md == 0) && (ex_mult || ex_div) && !flush && !data_busy;
    done   = (m_md == 2) && !flush;
    cancel = flush && (m_md != 0);
    disc   = m_disc && inst_busy;
    return {st[0], st[1], st[2], st[3], rf[0], rf[1], rf[2], rf[3],
            start, done, cancel, disc};
  endfunction

  task automatic model_update();
    logic flush;
    int   n;
    flush = exc_valid | eret_valid;
    if (!resetn) begin
      m_md   = 0;
      m_left = 0;
      m_disc = 1'b0;
      return;
    end
    m_disc = inst_busy && (m_disc || flush);
    if (flush) begin
      m_md = 0;
    end else if (m_md == 0) begin
      if ((ex_mult || ex_div) && !data_busy) begin
        n = ex_div ? DIV_CYCLES : MUL_CYCLES;
        if (n == 1) m_md = 2;
        else begin
          m_md   = 1;
          m_left = n - 1;
        end
      end
    end else if (m_md == 1) begin
      if (!data_busy) begin
        m_left--;
        if (m_left == 0) m_md = 2;
      end
    end else begin
      if (!data_busy) m_md = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    resetn     = 1'b1;
    id_rs_ren  = 1'b0; id_rt_ren = 1'b0;
    id_rs      = 5'd0; id_rt     = 5'd0;
    ex_load    = 1'b0; ex_regwen = 1'b0; ex_wreg = 5'd0;
    ex_mult    = 1'b0; ex_div    = 1'b0;
    inst_busy  = 1'b0; data_busy = 1'b0;
    exc_valid  = 1'b0; eret_valid = 1'b0;
  endtask

  task automatic random_inputs();
    int r;
    resetn    = ($urandom_range(0, 399) != 0);
    id_rs_ren = $urandom_range(0, 1) == 1;
    id_rt_ren = $urandom_range(0, 1) == 1;
    id_rs     = 5'($urandom_range(0, 3));
    id_rt     = 5'($urandom_range(0, 3));
    ex_load   = $urandom_range(0, 2) == 0;
    ex_regwen = $urandom_range(0, 3) != 0;
    ex_wreg   = 5'($urandom_range(0, 3));
    r         = $urandom_range(0, 19);
    ex_mult   = (r == 0) || (r == 2);
    ex_div    = (r == 1) || (r == 2);
    data_busy = $urandom_range(0, 5) == 0;
    inst_busy = $urandom_range(0, 2) == 0;
    exc_valid = $urandom_range(0, 59) == 0;
    eret_valid = $urandom_range(0, 79) == 0;
  endtask

  // Compare this cycle's outputs against the model, then advance one edge.
  task automatic step(input string tag);
    exp_q.push_back(model_expect());
    #3;
    obs = dut_vec;
    check(tag, 32'(obs), 32'(exp_q.pop_front()));
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int starts, done_at, cnt;

    // reset with noisy inputs: outputs must stay low
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      random_inputs();
      resetn = 1'b0;
      step("reset");
      check("reset_outs", 32'(obs), 32'd0);
    end

    // load-use on rs
    idle_inputs();
    ex_load = 1'b1; ex_regwen = 1'b1; ex_wreg = 5'd5;
    id_rs_ren = 1'b1; id_rs = 5'd5;
    step("lu");
    check("lu_if_id_stall", 32'(obs[11]), 32'd1);
    check("lu_id_ex_refresh", 32'(obs[6]), 32'd1);
    idle_inputs();
    step("lu_after");
    check("lu_after_clear", 32'({obs[11], obs[6]}), 32'd0);
    // load-use against r0 never stalls
    ex_load = 1'b1; ex_regwen = 1'b1; ex_wreg = 5'd0;
    id_rs_ren = 1'b1; id_rs = 5'd0;
    step("lu_r0");
    check("lu_r0_no_stall", 32'(obs[11]), 32'd0);

    // division occupying EX
    idle_inputs();
    ex_div = 1'b1;
    starts = 0; done_at = -1; cnt = 0;
    for (int c = 0; c < 80; c++) begin
      step("div");
      if (obs[3]) starts++;
      if (c > 0 && obs[11] && obs[10] && obs[5]) cnt++;
      if (obs[2]) begin
        done_at = c;
        check("div_done_no_stall", 32'(obs[11:8]), 32'd0);
        break;
      end
    end
    idle_inputs();
    step("div_after");
    check("div_starts", 32'(starts), 32'd1);
    check("div_done_at", 32'(done_at), 32'(DIV_CYCLES));
    check("div_hold_cycles", 32'(cnt), 32'(DIV_CYCLES - 1));

    // mult with data bus wait in the middle
    idle_inputs();
    ex_mult = 1'b1;
    done_at = -1; cnt = 0;
    for (int c = 0; c < 40; c++) begin
      data_busy = (c >= 1 && c <= 3);
      step("mul_db");
      if (obs[4]) cnt++;
      if (obs[2]) begin
        done_at = c;
        break;
      end
    end
    idle_inputs();
    step("mul_after");
    check("mul_done_at", 32'(done_at), 32'(MUL_CYCLES + 3));
    check("mul_wb_bubbles", 32'(cnt), 32'd3);

    // exception during a division
    idle_inputs();
    ex_div = 1'b1;
    for (int c = 0; c < 10; c++) step("div_exc_run");
    exc_valid = 1'b1;
    step("div_exc");
    check("exc_cancel", 32'(obs[1]), 32'd1);
    check("exc_refresh", 32'(obs[7:4]), 32'hF);
    idle_inputs();
    step("exc_after");
    check("exc_after_idle", 32'(obs), 32'd0);

    // eret with fetch outstanding for 4 more cycles
    idle_inputs();
    eret_valid = 1'b1; inst_busy = 1'b1;
    step("eret");
    eret_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step("eret_wait");
      if (obs[0] && obs[7]) cnt++;
    end
    check("eret_discard_cycles", 32'(cnt), 32'd4);
    inst_busy = 1'b0;
    step("eret_end");
    check("eret_end_clear", 32'({obs[7], obs[0]}), 32'd0);

    // reset in the middle of a division
    idle_inputs();
    ex_div = 1'b1;
    for (int c = 0; c < 5; c++) step("div_rst_run");
    resetn = 1'b0;
    step("div_rst");
    idle_inputs();
    step("div_rst_after");
    check("div_rst_outs", 32'(obs), 32'd0);
    check("div_rst_state", 32'(dbg_md_state), 32'd0);

    // reset while waiting to discard a fetch
    eret_valid = 1'b1; inst_busy = 1'b1;
    step("fl_rst_eret");
    eret_valid = 1'b0;
    resetn = 1'b0;
    step("fl_rst");
    resetn = 1'b1;
    step("fl_rst_after");
    check("fl_rst_discard", 32'(obs[0]), 32'd0);
    check("fl_rst_state", 32'(dbg_fl_state), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
